// File: rtl/sm_addsub_pipe.sv
// Two-stage pipelined sign-magnitude adder/subtractor with valid/ready handshake.
// Define SM_ADDSUB_SATURATE_EN to saturate the magnitude on overflow instead of wrapping.
module sm_addsub_pipe #(
  parameter int unsigned N = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic         i_op,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [N-1:0] o_out,
  output logic         o_carry,
  output logic         o_zero
);

  localparam int unsigned MW = N - 1;

  logic          s2_load;
  logic          s1_load;

  logic          s1_valid_q;
  logic          s1_sa_q;
  logic          s1_sb_q;
  logic          s1_same_q;
  logic          s1_ge_q;
  logic [MW-1:0] s1_ma_q;
  logic [MW-1:0] s1_mb_q;

  logic          sa_c;
  logic          sb_c;
  logic [MW-1:0] ma_c;
  logic [MW-1:0] mb_c;

  logic [MW:0]   sum_c;
  logic [MW-1:0] mag_c;
  logic          sign_c;
  logic          carry_c;
  logic          zero_c;

  logic          valid_q;
  logic [N-1:0]  out_q;
  logic          carry_q;
  logic          zero_q;

  // Stage 2 advances when empty or draining; stage 1 advances when empty or stage 2 advances.
  always_comb begin
    s2_load = !valid_q || i_ready;
    s1_load = !s1_valid_q || s2_load;
  end

  assign o_ready = s1_load;

  // Operand decode: subtraction flips the effective sign of B.
  always_comb begin
    sa_c = i_a[N-1];
    sb_c = i_b[N-1] ^ i_op;
    ma_c = i_a[MW-1:0];
    mb_c = i_b[MW-1:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_q <= 1'b0;
      s1_sa_q    <= 1'b0;
      s1_sb_q    <= 1'b0;
      s1_same_q  <= 1'b0;
      s1_ge_q    <= 1'b0;
      s1_ma_q    <= '0;
      s1_mb_q    <= '0;
    end else if (s1_load) begin
      s1_valid_q <= i_valid;
      if (i_valid) begin
        s1_sa_q   <= sa_c;
        s1_sb_q   <= sb_c;
        s1_same_q <= (sa_c == sb_c);
        s1_ge_q   <= (ma_c >= mb_c);
        s1_ma_q   <= ma_c;
        s1_mb_q   <= mb_c;
      end
    end
  end

  assign sum_c = {1'b0, s1_ma_q} + {1'b0, s1_mb_q};

  // Result magnitude/sign selection, overflow handling and negative-zero cleanup.
  always_comb begin
    mag_c   = '0;
    sign_c  = 1'b0;
    carry_c = 1'b0;
    zero_c  = 1'b0;
    if (s1_same_q) begin
      mag_c   = sum_c[MW-1:0];
      sign_c  = s1_sa_q;
      carry_c = sum_c[MW];
    end else if (s1_ge_q) begin
      mag_c  = s1_ma_q - s1_mb_q;
      sign_c = s1_sa_q;
    end else begin
      mag_c  = s1_mb_q - s1_ma_q;
      sign_c = s1_sb_q;
    end
`ifdef SM_ADDSUB_SATURATE_EN
    if (carry_c) begin
      mag_c = '1;
    end
`endif
    zero_c = (mag_c == '0);
    if (zero_c) begin
      sign_c = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      out_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else if (s2_load) begin
      valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_q   <= {sign_c, mag_c};
        carry_q <= carry_c;
        zero_q  <= zero_c;
      end
    end
  end

  assign o_valid = valid_q;
  assign o_out   = out_q;
  assign o_carry = carry_q;
  assign o_zero  = zero_q;

endmodule

// File: tb/tb_sm_addsub_pipe.sv
// Bench for sm_addsub_pipe: integer reference model, scoreboard queue and directed scenarios.
module tb_sm_addsub_pipe;

  localparam int unsigned N = 8;

  logic         clk = 1'b0;
  logic         i_rst;
  logic         i_valid;
  logic         o_ready;
  logic         i_op;
  logic [N-1:0] i_a;
  logic [N-1:0] i_b;
  logic         o_valid;
  logic         i_ready;
  logic [N-1:0] o_out;
  logic         o_carry;
  logic         o_zero;

  int n_tests = 0;
  int n_fail  = 0;
  int n_in    = 0;
  int n_out   = 0;

  logic [9:0] exp_q[$];

  sm_addsub_pipe #(.N(N)) dut (
    .i_clk   (clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_op    (i_op),
    .i_a     (i_a),
    .i_b     (i_b),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_out   (o_out),
    .o_carry (o_carry),
    .o_zero  (o_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Signed-integer reference: returns {zero, carry, out[7:0]}.
  function automatic logic [9:0] model(input logic op, input logic [7:0] a, input logic [7:0] b);
    int va, vb, r, mag, mo;
    logic c, s;
    va  = a[7] ? -int'(a[6:0]) : int'(a[6:0]);
    vb  = (b[7] ^ op) ? -int'(b[6:0]) : int'(b[6:0]);
    r   = va + vb;
    mag = (r < 0) ? -r : r;
    c   = (mag > 127);
`ifdef SM_ADDSUB_SATURATE_EN
    mo  = c ? 127 : mag;
`else
    mo  = mag % 128;
`endif
    s   = (r < 0) && (mo != 0);
    return {(mo == 0), c, s, 7'(mo)};
  endfunction

  // Scoreboard: checks every output transfer, stall stability and ready behaviour.
  logic       held;
  logic [9:0] held_val;
  initial held = 1'b0;

  always @(negedge clk) begin
    if (i_rst) begin
      exp_q.delete();
      held = 1'b0;
    end else begin
      chk("o_ready", o_ready, !(exp_q.size() == 2 && !i_ready));
      if (held && o_valid) chk("hold", {o_zero, o_carry, o_out}, held_val);
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) chk("spurious_out", 1, 0);
        else chk("result", {o_zero, o_carry, o_out}, exp_q.pop_front());
        n_out++;
      end
      held     = o_valid && !i_ready;
      held_val = {o_zero, o_carry, o_out};
      if (i_valid && o_ready) begin
        exp_q.push_back(model(i_op, i_a, i_b));
        n_in++;
      end
    end
  end

  // Single transaction on an idle pipeline with literal expectations and latency check.
  task automatic run_one(input string name, input logic op, input logic [7:0] a,
                         input logic [7:0] b, input logic [9:0] exp);
    i_valid = 1'b1; i_op = op; i_a = a; i_b = b;
    @(posedge clk); #1;
    i_valid = 1'b0;
    chk({name, "_lat1"}, o_valid, 0);
    @(posedge clk); #1;
    chk({name, "_lat2"}, o_valid, 1);
    chk({name, "_val"}, {o_zero, o_carry, o_out}, exp);
    @(posedge clk); #1;
  endtask

  logic [7:0] bp_a[4] = '{8'h05, 8'h85, 8'h7F, 8'h10};
  logic [7:0] bp_b[4] = '{8'h03, 8'h07, 8'h01, 8'h90};

  initial begin
    int sent, low_at, n0, i0;
    logic saw_low;
    i_rst = 1'b1; i_valid = 1'b0; i_op = 1'b0; i_a = '0; i_b = '0; i_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 i_rst = 1'b0;
    chk("rst_valid", o_valid, 0);
    chk("rst_out", {o_zero, o_carry, o_out}, 0);
    chk("rst_ready", o_ready, 1);

    // Pin the reference model with hand-computed values.
    chk("m_add", model(0, 8'h05, 8'h03), 10'h008);
    chk("m_sub_neg", model(1, 8'h05, 8'h07), 10'h082);
    chk("m_nz_sub", model(1, 8'h85, 8'h85), 10'h200);
    chk("m_nz_add", model(0, 8'h80, 8'h00), 10'h200);
`ifdef SM_ADDSUB_SATURATE_EN
    chk("m_ovf", model(0, 8'h7F, 8'h01), 10'h17F);
    chk("m_ovf_neg", model(0, 8'hFF, 8'h81), 10'h1FF);
`else
    chk("m_ovf", model(0, 8'h7F, 8'h01), 10'h300);
    chk("m_ovf_neg", model(0, 8'hFF, 8'h81), 10'h300);
`endif

    // Directed cases against literals.
    run_one("add", 0, 8'h05, 8'h03, 10'h008);
    run_one("sub_neg", 1, 8'h05, 8'h07, 10'h082);
    run_one("nz_sub", 1, 8'h85, 8'h85, 10'h200);
    run_one("nz_add", 0, 8'h80, 8'h00, 10'h200);
`ifdef SM_ADDSUB_SATURATE_EN
    run_one("ovf", 0, 8'h7F, 8'h01, 10'h17F);
    run_one("ovf_neg", 0, 8'hFF, 8'h81, 10'h1FF);
`else
    run_one("ovf", 0, 8'h7F, 8'h01, 10'h300);
    run_one("ovf_neg", 0, 8'hFF, 8'h81, 10'h300);
`endif

    // Backpressure: downstream stalls for cycles 2..6 while four ops stream in.
    sent = 0; saw_low = 1'b0; low_at = -1; n0 = n_out;
    for (int c = 0; c < 40 && (sent < 4 || exp_q.size() > 0); c++) begin
      i_ready = !(c >= 2 && c <= 6);
      i_valid = (sent < 4);
      i_op    = 1'b0;
      i_a     = bp_a[sent % 4];
      i_b     = bp_b[sent % 4];
      @(negedge clk);
      if (!o_ready && !saw_low) begin saw_low = 1'b1; low_at = sent; end
      if (i_valid && o_ready) sent++;
      @(posedge clk); #1;
    end
    i_valid = 1'b0; i_ready = 1'b1;
    chk("bp_sent", sent, 4);
    chk("bp_ready_low", saw_low, 1);
    chk("bp_low_after", low_at, 2);
    chk("bp_drained", n_out - n0, 4);

    // Reset with both stages full.
    i_ready = 1'b0; sent = 0;
    for (int c = 0; c < 20 && sent < 2; c++) begin
      i_valid = 1'b1; i_op = 1'b0; i_a = 8'h11; i_b = 8'h22;
      @(negedge clk);
      if (o_ready) sent++;
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    chk("full_sent", sent, 2);
    chk("full_ready", o_ready, 0);
    i_rst = 1'b1; i_valid = 1'b1; i_a = 8'h33; i_b = 8'h44;
    @(posedge clk); #1;
    i_rst = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    chk("mrst_valid", o_valid, 0);
    chk("mrst_out", {o_zero, o_carry, o_out}, 0);
    chk("mrst_ready", o_ready, 1);
    run_one("post_rst", 0, 8'h05, 8'h03, 10'h008);

    // Full-throughput random stream.
    n0 = n_out; i0 = n_in;
    for (int k = 0; k < 1000; k++) begin
      i_valid = 1'b1;
      i_op    = 1'($urandom);
      i_a     = 8'($urandom);
      i_b     = 8'($urandom);
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk); #1;
    chk("rnd_in", n_in - i0, 1000);
    chk("rnd_out", n_out - n0, 1000);
    chk("rnd_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
